// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage BTB pipeline.
// Resolves load-use stalls, mispredict flushes and syscall halt; keeps perf counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic [4:0]       EX_WAdr,
  input  logic             EX_MemToReg,
  input  logic             EX_RegWrite,
  input  logic             EX_Mispredict,
  input  logic             MEM_Halt,
  input  logic             WB_Valid,
  output logic             PC_En,
  output logic             IFID_En,
  output logic             IFID_CLR,
  output logic             IDEX_CLR,
  output logic             EXMEM_CLR,
  output logic             Halted,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] RetireCnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state;

  logic rs_hit;
  logic rt_hit;
  logic luh;
  logic take_hlt;
  logic take_mis;
  logic take_luh;

  assign rs_hit = ID_UsesRs && (ID_Rs == EX_WAdr);
  assign rt_hit = ID_UsesRt && (ID_Rt == EX_WAdr);
  assign luh    = EX_MemToReg && EX_RegWrite &&
                  (EX_WAdr != 5'd0) && (rs_hit || rt_hit);

  // One-hot resolution of hlt > mis > luh
  assign take_hlt = MEM_Halt;
  assign take_mis = EX_Mispredict && !MEM_Halt;
  assign take_luh = luh && !EX_Mispredict && !MEM_Halt;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    PC_En     = 1'b1;
    IFID_En   = 1'b1;
    IFID_CLR  = 1'b0;
    IDEX_CLR  = 1'b0;
    EXMEM_CLR = 1'b0;
    if (RST || state == HALT) begin
      PC_En     = 1'b0;
      IFID_En   = 1'b0;
      IFID_CLR  = 1'b1;
      IDEX_CLR  = 1'b1;
      EXMEM_CLR = 1'b1;
    end else begin
      unique case (1'b1)
        take_hlt: begin
          PC_En     = 1'b0;
          IFID_En   = 1'b0;
          IFID_CLR  = 1'b1;
          IDEX_CLR  = 1'b1;
          EXMEM_CLR = 1'b1;
        end
        take_mis: begin
          IFID_CLR  = 1'b1;
          IDEX_CLR  = 1'b1;
        end
        take_luh: begin
          PC_En     = 1'b0;
          IFID_En   = 1'b0;
          IDEX_CLR  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Halted = (state == HALT) && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      CycleCnt  <= '0;
      StallCnt  <= '0;
      FlushCnt  <= '0;
      RetireCnt <= '0;
    end else begin
      if (WB_Valid)
        RetireCnt <= sat_inc(RetireCnt);
      unique case (state)
        RUN: begin
          CycleCnt <= sat_inc(CycleCnt);
          if (take_hlt)
            state <= HALT;
          if (take_mis)
            FlushCnt <= sat_inc(FlushCnt);
          if (take_luh)
            StallCnt <= sat_inc(StallCnt);
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Runs a 32-bit instance and a 4-bit instance on shared stimulus.
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  ID_Rs, ID_Rt, EX_WAdr;
  logic        ID_UsesRs, ID_UsesRt;
  logic        EX_MemToReg, EX_RegWrite;
  logic        EX_Mispredict, MEM_Halt, WB_Valid;
  logic        PC_En, IFID_En, IFID_CLR, IDEX_CLR, EXMEM_CLR;
  logic        Halted;
  logic [31:0] CycleCnt, StallCnt, FlushCnt, RetireCnt;
  logic        s_pc, s_ifen, s_ifclr, s_idclr, s_exclr, s_halt;
  logic [3:0]  s_cyc, s_stall, s_flush, s_ret;

  int vecs = 0;
  int errs = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .EX_WAdr(EX_WAdr), .EX_MemToReg(EX_MemToReg),
    .EX_RegWrite(EX_RegWrite), .EX_Mispredict(EX_Mispredict),
    .MEM_Halt(MEM_Halt), .WB_Valid(WB_Valid),
    .PC_En(PC_En), .IFID_En(IFID_En), .IFID_CLR(IFID_CLR),
    .IDEX_CLR(IDEX_CLR), .EXMEM_CLR(EXMEM_CLR), .Halted(Halted),
    .CycleCnt(CycleCnt), .StallCnt(StallCnt),
    .FlushCnt(FlushCnt), .RetireCnt(RetireCnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .EX_WAdr(EX_WAdr), .EX_MemToReg(EX_MemToReg),
    .EX_RegWrite(EX_RegWrite), .EX_Mispredict(EX_Mispredict),
    .MEM_Halt(MEM_Halt), .WB_Valid(WB_Valid),
    .PC_En(s_pc), .IFID_En(s_ifen), .IFID_CLR(s_ifclr),
    .IDEX_CLR(s_idclr), .EXMEM_CLR(s_exclr), .Halted(s_halt),
    .CycleCnt(s_cyc), .StallCnt(s_stall),
    .FlushCnt(s_flush), .RetireCnt(s_ret)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks PC_En, IFID_En, IFID_CLR, IDEX_CLR, EXMEM_CLR as one vector
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, PC_En, IFID_En, IFID_CLR, IDEX_CLR, EXMEM_CLR},
        {27'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input int c, input int s,
                         input int f, input int r);
    chk({tag, "_cyc"},   CycleCnt,  c);
    chk({tag, "_stall"}, StallCnt,  s);
    chk({tag, "_flush"}, FlushCnt,  f);
    chk({tag, "_ret"},   RetireCnt, r);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_in();
    ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0;
    EX_WAdr = 0; EX_MemToReg = 0; EX_RegWrite = 0;
    EX_Mispredict = 0; MEM_Halt = 0; WB_Valid = 0;
  endtask

  task automatic set_load(input logic [4:0] wadr);
    EX_WAdr = wadr; EX_MemToReg = 1; EX_RegWrite = 1;
  endtask

  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11110;
  localparam logic [4:0] SQSH  = 5'b00111;

  initial begin
    RST = 1;
    clr_in();
    tick();
    tick();
    chk_ctl("rst_ctl", SQSH);
    chk("rst_halted", Halted, 0);
    chk_cnt("rst", 0, 0, 0, 0);

    RST = 0;
    #1;
    chk_ctl("run_norm", NORM);
    chk("run_halted", Halted, 0);
    tick();
    chk("cyc1", CycleCnt, 1);

    ID_Rs = 5; ID_UsesRs = 1; set_load(5);
    #1;
    chk_ctl("luh_rs", STALL);
    tick();
    chk("stall1", StallCnt, 1);

    clr_in();
    #1;
    chk_ctl("after_luh", NORM);
    tick();

    set_load(0); ID_Rs = 0; ID_UsesRs = 1;
    #1;
    chk_ctl("zero_reg", NORM);
    tick();

    set_load(7); ID_Rs = 7; ID_UsesRs = 0;
    ID_Rt = 3; ID_UsesRt = 1;
    #1;
    chk_ctl("unused_rs", NORM);
    tick();
    chk("stall_still1", StallCnt, 1);

    ID_Rt = 7;
    #1;
    chk_ctl("luh_rt", STALL);
    tick();
    chk("stall2", StallCnt, 2);

    EX_Mispredict = 1;
    #1;
    chk_ctl("mis_luh", FLUSH);
    tick();
    chk_cnt("mis1", 7, 2, 1, 0);

    clr_in();
    EX_Mispredict = 1; WB_Valid = 1;
    #1;
    chk_ctl("mis2", FLUSH);
    tick();
    chk_cnt("mis2", 8, 2, 2, 1);

    WB_Valid = 0; MEM_Halt = 1;
    ID_Rs = 9; ID_UsesRs = 1; set_load(9);
    #1;
    chk_ctl("hlt_req", SQSH);
    chk("hlt_req_halted", Halted, 0);
    tick();
    chk("halted_rise", Halted, 1);
    chk_cnt("hlt", 9, 2, 2, 1);

    MEM_Halt = 0; WB_Valid = 1;
    #1;
    chk_ctl("halt_ctl", SQSH);
    tick();
    chk_cnt("halt1", 9, 2, 2, 2);

    WB_Valid = 0;
    tick();
    tick();
    chk_cnt("halt3", 9, 2, 2, 2);
    chk("halt_hold", Halted, 1);
    chk_ctl("halt_ctl2", SQSH);

    RST = 1;
    #1;
    chk_ctl("rst_in_halt", SQSH);
    chk("rst_in_halt_h", Halted, 0);
    tick();
    chk_ctl("rst_held", SQSH);
    chk_cnt("rst_halt", 0, 0, 0, 0);

    RST = 0;
    clr_in();
    #1;
    chk("rel_halted", Halted, 0);
    chk_ctl("rel_ctl", NORM);

    for (int i = 0; i < 20; i++) tick();
    chk("sat4_cyc", {28'd0, s_cyc}, 15);
    chk("wide_cyc", CycleCnt, 20);
    tick();
    chk("sat4_hold", {28'd0, s_cyc}, 15);
    chk("wide_cyc2", CycleCnt, 21);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and sequencing controller for the five-stage redirecting pipeline with BTB. Each cycle it drives the PC enable, the IF/ID enable and clear, and the clears of the ID/EX and EX/MEM pipeline registers. It resolves load-use stalls, BTB mispredict flushes and the syscall-halt drain through a small run/halt state machine. It also keeps saturating performance counters (cycles, stalls, flushes, retired instructions) for the board display.

## Interface
- CNT_W, 32: width of every performance counter.

- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRs  in  1  ID instruction reads rs.
- ID_UsesRt  in  1  ID instruction reads rt.
- EX_WAdr  in  5  destination register of the instruction in EX.
- EX_MemToReg  in  1  instruction in EX is a load.
- EX_RegWrite  in  1  instruction in EX writes the register file.
- EX_Mispredict  in  1  branch/jump resolved in EX disagrees with the BTB prediction.
- MEM_Halt  in  1  instruction in MEM is a halting syscall.
- WB_Valid  in  1  a non-bubble instruction is in WB this cycle.
- PC_En  out  1  PC register load enable.
- IFID_En  out  1  IF/ID register load enable.
- IFID_CLR  out  1  IF/ID synchronous clear.
- IDEX_CLR  out  1  ID/EX synchronous clear (bubble insert).
- EXMEM_CLR  out  1  EX/MEM synchronous clear.
- Halted  out  1  controller is in HALT.
- CycleCnt  out  CNT_W  cycles spent running.
- StallCnt  out  CNT_W  load-use stall cycles taken.
- FlushCnt  out  CNT_W  mispredict flushes taken.
- RetireCnt  out  CNT_W  instructions retired.

## Operation
- States are RUN and HALT. Reset enters RUN.
- Decoded conditions, all combinational:
  - luh = EX_MemToReg & EX_RegWrite & (EX_WAdr != 0) & ((ID_UsesRs & ID_Rs == EX_WAdr) | (ID_UsesRt & ID_Rt == EX_WAdr)).
  - mis = EX_Mispredict.
  - hlt = MEM_Halt.
- Priority in RUN is hlt > mis > luh > normal.
  - **Normal:** PC_En=1, IFID_En=1, all CLR=0.
  - **Load-use (luh only):** PC_En=0, IFID_En=0, IDEX_CLR=1, others 0. StallCnt += 1.
  - **Mispredict (mis, no hlt):** PC_En=1 to take the redirect, IFID_En=1, IFID_CLR=1, IDEX_CLR=1, EXMEM_CLR=0. FlushCnt += 1. A simultaneous luh is discarded and StallCnt does not increment.
  - **Halt request (hlt):** PC_En=0, IFID_En=0, IFID_CLR=1, IDEX_CLR=1, EXMEM_CLR=1. This squashes all instructions younger than the syscall. The MEM/WB register is untouched, so the syscall itself retires. Next state is HALT. A simultaneous mis or luh is ignored and neither counter increments.
- **HALT:** PC_En=0, IFID_En=0, IFID_CLR=1, IDEX_CLR=1, EXMEM_CLR=1, Halted=1. Inputs are ignored. Only RST leaves HALT.
- **While RST=1:** PC_En=0, IFID_En=0, all CLR=1, Halted=0. No counter increments.
- **Counters:**
  - CycleCnt increments every non-reset cycle in RUN, including the halt-request cycle.
  - RetireCnt increments every non-reset cycle with WB_Valid=1, in either state, so the syscall that retires in the first HALT cycle is counted.
  - All counters saturate at 2^CNT_W−1 and never wrap.
- Arithmetic is unsigned. Register comparisons are full 5-bit equality. $0 never causes a stall.

## Timing
- Control outputs are combinational from the current inputs and the registered state, and take effect at the next CLK edge in the pipeline registers.
- State, Halted and counters are registered. Halted rises on the edge after the hlt cycle.
- After reset deassertion: first cycle is in RUN, all counters read 0, Halted=0.
- A load-use stall lasts exactly one cycle. On the next cycle the load has moved to MEM, so luh deasserts naturally. No internal stall counter is needed.
- Back-to-back mispredicts each flush and each increment FlushCnt.
- RST asserted mid-HALT or mid-stall returns to RUN on the next edge and clears all counters.

## Test plan
- **Load-use:** lw $5 in EX (EX_WAdr=5, MemToReg=1, RegWrite=1), ID_Rs=5, UsesRs=1.
  - Same cycle: PC_En=0, IFID_En=0, IDEX_CLR=1.
  - Next cycle with the load gone: normal outputs.
  - StallCnt=1.
- **$0 and unused-operand cases:** EX_WAdr=0 with matching Rs, or a match with UsesRs=0 → no stall, StallCnt stays 0.
- **Mispredict with luh in the same cycle:** IFID_CLR=1, IDEX_CLR=1, PC_En=1, EXMEM_CLR=0. FlushCnt=1, StallCnt=0.
- **Halt with mis and luh in the same cycle:**
  - Same cycle: all three CLR=1, PC_En=0.
  - Next edge: Halted=1.
  - WB_Valid=1 in that next cycle → RetireCnt increments.
  - CycleCnt freezes thereafter, and further mis/luh inputs have no effect.
- **RST during HALT:**
  - While RST=1: all CLR=1, PC_En=0, Halted=0.
  - After release: RUN, all counters 0.
- **Saturation:** with CNT_W=4, hold luh-free running for 20 cycles → CycleCnt=15 and stays 15.
